mux_4x1_rr_arbiter: RTL
=======================

# mux_4x1_rr_arbiter

Round-robin arbiter that shares one 4:1 multiplexer between four requesters. It accepts a request vector, grants the mux to one requester at a time and drives the mux select lines. A hold limit stops one requester from keeping the mux while others wait. It sits directly in front of the 4:1 mux and replaces the static select stimulus used in standalone mux tests.

## Interface

- MAX_HOLD, default 8: maximum consecutive grant cycles while another request is pending. Legal range 0..255. 0 disables preemption.
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  4  request vector; bit i = requester i (0→a, 1→b, 2→c, 3→d)
- grant  output  4  one-hot grant, registered; all zero when idle
- sl_0  output  1  mux select LSB, registered
- sl_1  output  1  mux select MSB, registered
- busy  output  1  registered; equals |grant

## Operation

- State: FSM {IDLE, OWNED}, 2-bit owner index, 2-bit round-robin pointer ptr, hold counter hcnt (8 bits, saturating).
- Arbitration function: winner = first i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE:
  - req==0: stay.
  - else: owner=winner, grant=onehot(winner), {sl_1,sl_0}=winner, hcnt=0, go OWNED.
- OWNED, evaluated each edge, in priority order:
  - Release: req[owner]=0. ptr=owner+1 (mod 4). If any other req bit is set, the grant moves directly to the new winner with no idle cycle and hcnt=0. Otherwise grant=0 and go IDLE.
  - Preempt: MAX_HOLD≠0, hcnt==MAX_HOLD-1 and (req & ~onehot(owner))≠0. ptr=owner+1. The grant moves to the winner among the other requesters. Owner loses the grant even though it is still requesting, and re-enters the rotation. hcnt=0.
  - Otherwise: hold the grant. hcnt increments and saturates at 255.
- Select lines hold the last owner index while IDLE. They change only on a new grant.
- Requesters must keep req asserted while they need the mux. The arbiter does not latch a request pulse that is sampled low before it wins.
- Reset values (async, on rst_n low): grant=0000, sl_0=0, sl_1=0, busy=0, ptr=0, hcnt=0, state IDLE. Reset during OWNED drops the grant immediately, without waiting for a clock edge.

## Timing

- All outputs are registered. There is no combinational path from req to any output.
- Grant latency: req sampled at edge N, then grant, sl and busy are valid after edge N. One cycle from request assertion to grant.
- Release latency: req[owner] sampled low at edge N, then the grant changes after edge N. There is no overlap, and grant is never more than one-hot.
- Handover between requesters is back-to-back with zero idle cycles. sl and grant switch on the same edge.
- Preemption: an owner that requests continuously while another requester waits holds the grant for exactly MAX_HOLD cycles.
- Simultaneous requests: resolved by ptr. After reset, ptr=0, so req=1111 grants requester 0 first.
- Owner release on the same edge as a new request: the new request competes normally with ptr=owner+1.
- Pointer wrap: owner 3 releases, so ptr=0.
- Reset deassertion: the first grant is possible on the first edge after rst_n goes high.

## Test plan

- Reset check: assert rst_n=0 mid-grant with req=0100. Required: grant=0000, sl=00 and busy=0 immediately, before any clock edge.
- Single requester: req=0100 for 5 cycles, then 0000. Required: grant=0100 and {sl_1,sl_0}=10 from the first edge through 5 cycles. Then grant=0000 with sl held at 10.
- Round-robin fairness: each requester drops its req one cycle after it is granted, from req=1111. Required: grant sequence 0001, 0010, 0100, 1000, 0001, with no idle cycle between grants.
- Preemption with MAX_HOLD=4: req=0011 held constant. Required: grant=0001 for 4 cycles, then 0010 for 4 cycles, then 0001.
- No preemption without contention: MAX_HOLD=4 and req=1000 for 20 cycles. Required: grant=1000 for all 20 cycles and sl=11.
- Mux integration: connect sl to a 4:1 mux with a=0, b=1, c=0, d=1. Required: the mux output follows the granted input on every cycle of the round-robin sequence.

Source files
------------

// File: rtl/mux_4x1_rr_arbiter_if.sv
// Request/grant/select bundle between four requesters and the round-robin mux arbiter.
// The master side drives requests; the slave (arbiter) side drives the grant and select.
interface mux_4x1_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic       sl_0;
  logic       sl_1;
  logic       busy;

  modport master (output req, input grant, sl_0, sl_1, busy);
  modport slave  (input req, output grant, sl_0, sl_1, busy);
endinterface

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four requesters, with a hold limit
// that forces a handover when an owner keeps the mux while others are waiting.
//
//   state | meaning
//   IDLE  | no grant; select lines hold the last owner index
//   OWNED | one requester holds the mux; hcnt counts its hold cycles
module mux_4x1_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_4x1_rr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam bit         PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST  = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [7:0] hcnt_q,  hcnt_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q,   sel_d;
  logic       busy_q,  busy_d;

  logic [3:0] owner_oh;
  logic [3:0] others_req;
  logic [1:0] win_idle;
  logic [1:0] win_next;

  // First set bit of r, searching upward from p with wrap.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign owner_oh   = 4'b0001 << owner_q;
  assign others_req = bus.req & ~owner_oh;
  assign win_idle   = rr_pick(bus.req, ptr_q);
  // On release req[owner] is already low, so one search over the others serves both handovers.
  assign win_next   = rr_pick(others_req, owner_q + 2'd1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          owner_d = win_idle;
          grant_d = 4'b0001 << win_idle;
          sel_d   = win_idle;
          hcnt_d  = 8'd0;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (!bus.req[owner_q]) begin
          ptr_d = owner_q + 2'd1;
          if (|others_req) begin
            owner_d = win_next;
            grant_d = 4'b0001 << win_next;
            sel_d   = win_next;
            hcnt_d  = 8'd0;
          end else begin
            grant_d = 4'b0000;
            state_d = IDLE;
          end
        end else if (PREEMPT_EN && (hcnt_q == HOLD_LAST) && (|others_req)) begin
          ptr_d   = owner_q + 2'd1;
          owner_d = win_next;
          grant_d = 4'b0001 << win_next;
          sel_d   = win_next;
          hcnt_d  = 8'd0;
        end else if (hcnt_q != 8'hFF) begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: begin
        grant_d = 4'b0000;
        state_d = IDLE;
      end
    endcase
    busy_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      hcnt_q  <= 8'd0;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.sl_0  = sel_q[0];
  assign bus.sl_1  = sel_q[1];
  assign bus.busy  = busy_q;

endmodule
